// File: rtl/bit_sparse_pkg.sv
// Shared definitions for the bit-sparsity datapath: term geometry, the
// accumulator state encoding and the signed-add overflow helper.
package bit_sparse_pkg;

  localparam int PLACE_W = 3;
  localparam int VALUE_W = 8;

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } acc_state_t;

  // Two's-complement add overflows when both operands agree in sign and the sum does not.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/bit_place_accumulator_if.sv
// Term input and group-result output channels of the bit-place accumulator.
interface bit_place_accumulator_if
  import bit_sparse_pkg::*;
#(
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) ();

  logic                in_valid;
  logic                in_ready;
  logic [PLACE_W-1:0]  in_place;
  logic                in_zero;
  logic                in_last;
  logic [WEIGHT_W-1:0] in_weight;

  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_sum;
  logic                out_overflow;

  modport master (
    output in_valid, in_place, in_zero, in_last, in_weight, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  in_valid, in_place, in_zero, in_last, in_weight, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );

endinterface

// File: rtl/bit_term_shifter.sv
// Turns one set-bit term into its accumulator contribution: the sign-extended
// weight moved to the bit's place, or zero for an empty activation.
module bit_term_shifter
  import bit_sparse_pkg::*;
#(
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) (
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic [PLACE_W-1:0]  in_place,
  input  logic                in_zero,
  output logic [ACC_W-1:0]    term
);

  logic signed [ACC_W-1:0] ext_s;

  // Sign-extend before shifting so bits pushed past ACC_W simply wrap.
  assign ext_s = ACC_W'($signed(in_weight));

  // Select the shifted weight, or nothing when the activation had no set bits.
  always_comb begin
    term = {ACC_W{1'b0}};
    if (in_zero) begin
      term = {ACC_W{1'b0}};
    end else begin
      term = ext_s << in_place;
    end
  end

endmodule

// File: rtl/bit_place_accumulator.sv
// Accumulates weight<<place terms over GROUP_LEN activations and hands the
// signed group sum, with a sticky overflow flag, to a valid/ready consumer.
module bit_place_accumulator
  import bit_sparse_pkg::*;
#(
  parameter int WEIGHT_W  = 8,
  parameter int ACC_W     = 24,
  parameter int GROUP_LEN = 16
) (
  input logic                     CLK,
  input logic                     RST,
  bit_place_accumulator_if.slave  bus
);

  localparam int CNT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUP_LEN - 1);

  acc_state_t       state_r;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;

  logic [ACC_W-1:0] term_s;
  logic [ACC_W-1:0] sum_s;
  logic             ovf_s;
  logic             in_ready_s;
  logic             hs_in_s;
  logic             done_s;

  bit_term_shifter #(
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_shifter (
    .in_weight (bus.in_weight),
    .in_place  (bus.in_place),
    .in_zero   (bus.in_zero),
    .term      (term_s)
  );

  assign in_ready_s = (state_r == S_ACC) && !RST;
  assign hs_in_s    = bus.in_valid && in_ready_s;
  assign done_s     = bus.in_last || bus.in_zero;
  assign sum_s      = acc_r + term_s;
  assign ovf_s      = add_overflow(acc_r[ACC_W-1], term_s[ACC_W-1], sum_s[ACC_W-1]);

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = (state_r == S_OUT);
  assign bus.out_sum      = acc_r;
  assign bus.out_overflow = ovf_r;

  // Accumulate terms, count completed activations, and hold the result until taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_ACC;
      acc_r   <= {ACC_W{1'b0}};
      ovf_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_ACC: begin
          if (hs_in_s) begin
            acc_r <= sum_s;
            ovf_r <= ovf_r | ovf_s;
            if (done_s) begin
              if (cnt_r == LAST_CNT) begin
                cnt_r   <= {CNT_W{1'b0}};
                state_r <= S_OUT;
              end else begin
                cnt_r <= cnt_r + CNT_W'(1);
              end
            end
          end
        end
        S_OUT: begin
          // acc/ovf stay frozen here so the result holds under backpressure.
          if (bus.out_ready) begin
            acc_r   <= {ACC_W{1'b0}};
            ovf_r   <= 1'b0;
            state_r <= S_ACC;
          end
        end
        default: begin
          state_r <= S_ACC;
          acc_r   <= {ACC_W{1'b0}};
          ovf_r   <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule
